// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS program loader.
package mips_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        BYTES,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_INDEX_W   = 8;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    // A word count is usable when it is non-zero and fits in instruction memory.
    function automatic logic header_ok(input logic [7:0] n, input int depth);
        return (n != 8'd0) && (int'(n) <= depth);
    endfunction

endpackage

// File: rtl/mips_program_loader_assembler.sv
// MSB-first byte-to-word shift register; `word` presents the value including the byte being shifted.
module byte_to_word_assembler
    import mips_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  i_byte,
    output logic        word_full,
    output logic [31:0] word
);

    logic [31:0]           word_q, word_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift) begin
            word_d = {word_q[23:0], i_byte};
            cnt_d  = cnt_q + 1'b1;
        end
    end

    assign word_full = shift && !clear && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    assign word      = word_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_program_loader.sv
// Framed byte-stream loader for the MIPS instruction memory; holds the core in reset until loaded.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module mips_program_loader
    import mips_loader_pkg::*;
#(
    parameter int MEMORY_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    output logic        o_wr_en,
    output logic [31:0] o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic        o_cpu_rst,
    output logic        o_done,
    output logic        o_error
);

    state_e                  state_q, state_d;
    logic [WORD_INDEX_W-1:0] n_q, n_d;
    logic [WORD_INDEX_W-1:0] idx_q, idx_d;
    logic [WORD_INDEX_W-1:0] idx_inc;
    logic                    ready_q, ready_d;
    logic                    wr_en_q, wr_en_d;
    logic [31:0]             wr_addr_q, wr_addr_d;
    logic [31:0]             wr_data_q, wr_data_d;
    logic                    cpu_rst_q, cpu_rst_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              xor_q, xor_d;
`endif

    logic        accept;
    logic        asm_clear;
    logic        asm_shift;
    logic        asm_full;
    logic [31:0] asm_word;

    byte_to_word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .shift     (asm_shift),
        .i_byte    (i_byte),
        .word_full (asm_full),
        .word      (asm_word)
    );

    assign accept  = i_byte_valid && ready_q;
    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        idx_d     = idx_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        asm_clear = 1'b0;
        asm_shift = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        xor_d     = xor_q;
`endif

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (i_start) state_d = HEADER;
            end
            HEADER: begin
                if (accept) begin
                    if (header_ok(i_byte, MEMORY_DEPTH)) begin
                        n_d       = i_byte;
                        idx_d     = '0;
                        asm_clear = 1'b1;
                        state_d   = BYTES;
`ifdef LOADER_CHECKSUM_EN
                        xor_d     = 8'h00;
`endif
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            BYTES: begin
                if (accept) begin
                    asm_shift = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    xor_d     = xor_q ^ i_byte;
`endif
                    // Address and data are latched here so they are stable for the whole WRITE cycle.
                    if (asm_full) begin
                        state_d   = WRITE;
                        wr_addr_d = 32'({idx_q, 2'b00});
                        wr_data_d = asm_word;
                    end
                end
            end
            WRITE: begin
                idx_d = idx_inc;
                if (idx_inc == n_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = BYTES;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) state_d = (i_byte == xor_q) ? DONE : ERROR;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        ready_d   = (state_d == HEADER) || (state_d == BYTES) || (state_d == CHECK);
        wr_en_d   = (state_d == WRITE);
        cpu_rst_d = (state_d != DONE);
        done_d    = (state_d == DONE);
        error_d   = (state_d == ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            idx_q     <= '0;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            error_q   <= error_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    assign o_byte_ready = ready_q;
    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_cpu_rst    = cpu_rst_q;
    assign o_done       = done_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_mips_program_loader.sv
// Directed bench for mips_program_loader: frame table plus hand-written corner sequences.
module tb_mips_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic        i_byte_valid;
    logic [7:0]  i_byte;
    logic        o_byte_ready;
    logic        o_wr_en;
    logic [31:0] o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_cpu_rst;
    logic        o_done;
    logic        o_error;

    always #5 clk = ~clk;

    mips_program_loader #(.MEMORY_DEPTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_byte_valid (i_byte_valid),
        .i_byte       (i_byte),
        .o_byte_ready (o_byte_ready),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_cpu_rst    (o_cpu_rst),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    always @(negedge clk) begin
        if (o_wr_en) begin
            wa_q.push_back(o_wr_addr);
            wd_q.push_back(o_wr_data);
            wc_q.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a byte and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        if (gap) begin
            i_byte_valid = 1'b0;
            i_byte       = 8'hFF;
            step();
        end
        i_byte       = b;
        i_byte_valid = 1'b1;
        t = 0;
        while (!o_byte_ready && t < 20) begin
            step();
            t++;
        end
        if (t >= 20) check("ready_timeout", 32'(o_byte_ready), 32'd1);
        step();
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    // Closes a frame: sends the checksum when enabled, otherwise steps past the last WRITE.
    task automatic end_frame(input logic [7:0] cks);
`ifdef LOADER_CHECKSUM_EN
        send_byte(cks, 1'b0);
        i_byte_valid = 1'b0;
`else
        i_byte_valid = 1'b0;
        check("last_wr_en", 32'(o_wr_en), 32'd1);
        check("done_before_final_edge", 32'(o_done), 32'd0);
        step();
        if (cks == 8'hxx) check("unreachable", 0, 0);
`endif
    endtask

    typedef struct {
        logic [7:0]       hdr;
        int               nw;
        logic [2:0][31:0] w;
        logic [7:0]       cks;
        bit               gaps;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] hdr, input int nw, input logic [31:0] w0,
                                input logic [31:0] w1, input logic [31:0] w2,
                                input logic [7:0] cks, input bit gaps);
        vec_t v;
        v.hdr  = hdr;
        v.nw   = nw;
        v.w[0] = w0;
        v.w[1] = w1;
        v.w[2] = w2;
        v.cks  = cks;
        v.gaps = gaps;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        vec_t r;

        // nw==0 marks a rejected header; checksums are the XOR of the data bytes.
        tbl[0] = mk(8'h02, 2, 32'h20080005, 32'h2009000A, 32'h0, 8'h0E, 1'b0);
        tbl[1] = mk(8'h00, 0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b0);
        tbl[2] = mk(8'h21, 0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b0);
        tbl[3] = mk(8'hFF, 0, 32'h0, 32'h0, 32'h0, 8'h00, 1'b0);
        tbl[4] = mk(8'h01, 1, 32'hDEADBEEF, 32'h0, 32'h0, 8'h22, 1'b0);
        tbl[5] = mk(8'h03, 3, 32'h00000001, 32'h00000002, 32'h00000003, 8'h00, 1'b0);
        tbl[6] = mk(8'h02, 2, 32'h20080005, 32'h2009000A, 32'h0, 8'h0E, 1'b1);

        rst          = 1'b1;
        i_start      = 1'b0;
        i_byte_valid = 1'b0;
        i_byte       = 8'h00;
        step();
        step();
        check("rst_ready",   32'(o_byte_ready), 32'd0);
        check("rst_wr_en",   32'(o_wr_en),      32'd0);
        check("rst_wr_addr", o_wr_addr,         32'd0);
        check("rst_wr_data", o_wr_data,         32'd0);
        check("rst_cpu_rst", 32'(o_cpu_rst),    32'd1);
        check("rst_done",    32'(o_done),       32'd0);
        check("rst_error",   32'(o_error),      32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            r = tbl[i];
            clear_log();
            pulse_start();
            check("start_cpu_rst", 32'(o_cpu_rst),    32'd1);
            check("start_ready",   32'(o_byte_ready), 32'd1);
            check("start_done",    32'(o_done),       32'd0);
            check("start_error",   32'(o_error),      32'd0);
            send_byte(r.hdr, r.gaps);
            if (r.nw == 0) begin
                i_byte_valid = 1'b0;
                check("hdr_error",   32'(o_error),   32'd1);
                check("hdr_cpu_rst", 32'(o_cpu_rst), 32'd1);
                check("hdr_done",    32'(o_done),    32'd0);
                step();
            end else begin
                for (int w = 0; w < r.nw; w++)
                    for (int b = 0; b < 4; b++)
                        send_byte(r.w[w][31-8*b -: 8], r.gaps);
                end_frame(r.cks);
                check("load_done",    32'(o_done),    32'd1);
                check("load_cpu_rst", 32'(o_cpu_rst), 32'd0);
                check("load_error",   32'(o_error),   32'd0);
            end
            check("wr_count", 32'(wa_q.size()), 32'(r.nw));
            for (int k = 0; k < r.nw && k < wa_q.size(); k++) begin
                check("wr_addr", wa_q[k], 32'(k * 4));
                check("wr_data", wd_q[k], r.w[k]);
            end
            if (!r.gaps && r.nw >= 2 && wc_q.size() >= 2)
                check("wr_spacing", 32'(wc_q[1] - wc_q[0]), 32'd5);
        end

        // Byte held during WRITE is not taken until WRITE ends.
        clear_log();
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        i_byte = 8'h55;
        i_byte_valid = 1'b1;
        check("hold_ready_in_write", 32'(o_byte_ready), 32'd0);
        check("hold_wr_en",          32'(o_wr_en),      32'd1);
        check("hold_wr_data",        o_wr_data,         32'h11223344);
        step();
        check("hold_ready_after",    32'(o_byte_ready), 32'd1);
        check("hold_wr_en_after",    32'(o_wr_en),      32'd0);
        check("hold_data_kept",      o_wr_data,         32'h11223344);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        // 11^22^33^44^55^66^77^88 = 0x88
        end_frame(8'h88);
        check("hold_done",    32'(o_done), 32'd1);
        check("hold_count",   32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            check("hold_addr1", wa_q[1], 32'h4);
            check("hold_data1", wd_q[1], 32'h55667788);
        end

        // Reset mid-load, together with i_start, then a fresh load.
        clear_log();
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h09, 1'b0);
        i_byte  = 8'h00;
        rst     = 1'b1;
        i_start = 1'b1;
        step();
        rst          = 1'b0;
        i_start      = 1'b0;
        i_byte_valid = 1'b0;
        check("mid_rst_ready",   32'(o_byte_ready), 32'd0);
        check("mid_rst_wr_en",   32'(o_wr_en),      32'd0);
        check("mid_rst_wr_addr", o_wr_addr,         32'd0);
        check("mid_rst_wr_data", o_wr_data,         32'd0);
        check("mid_rst_cpu_rst", 32'(o_cpu_rst),    32'd1);
        check("mid_rst_done",    32'(o_done),       32'd0);
        check("mid_rst_error",   32'(o_error),      32'd0);
        step();
        clear_log();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'hCA, 1'b0);
        send_byte(8'hFE, 1'b0);
        send_byte(8'hBA, 1'b0);
        send_byte(8'hBE, 1'b0);
        end_frame(8'h30);
        check("reload_done",  32'(o_done),       32'd1);
        check("reload_count", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() >= 1) begin
            check("reload_addr", wa_q[0], 32'h0);
            check("reload_data", wd_q[0], 32'hCAFEBABE);
        end

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksums: memory is written, but the frame is rejected.
        for (int c = 0; c < 2; c++) begin
            clear_log();
            pulse_start();
            send_byte(8'h02, 1'b0);
            send_byte(8'h20, 1'b0);
            send_byte(8'h08, 1'b0);
            send_byte(8'h00, 1'b0);
            send_byte(8'h05, 1'b0);
            send_byte(8'h20, 1'b0);
            send_byte(8'h09, 1'b0);
            send_byte(8'h00, 1'b0);
            send_byte(8'h0A, 1'b0);
            send_byte((c == 0) ? 8'h07 : 8'h06, 1'b0);
            i_byte_valid = 1'b0;
            check("cks_bad_error",   32'(o_error),      32'd1);
            check("cks_bad_cpu_rst", 32'(o_cpu_rst),    32'd1);
            check("cks_bad_done",    32'(o_done),       32'd0);
            check("cks_bad_writes",  32'(wa_q.size()),  32'd2);
            step();
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
